// File: rtl/kernel_bc_wb_pkg.sv
// rtl/kernel_bc_wb_pkg.sv - shared types and width defaults for the BC write-back controller
// Contents:
//   state_t            controller state encoding (IDLE, RUN, DONE)
//   DEF_*_WIDTH        default data / address / counter widths
package kernel_bc_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_CNT_WIDTH  = 32;

endpackage

// File: rtl/kernel_bc_wb_perf_cnt.sv
// rtl/kernel_bc_wb_perf_cnt.sv - saturating busy/stall cycle counter pair
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   busy_inc             count one busy cycle
//   stall_inc            count one stall cycle
//   perf_busy            busy cycle count, saturates at all-ones
//   perf_stall           stall cycle count, saturates at all-ones
module kernel_bc_wb_perf_cnt
  import kernel_bc_wb_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 busy_inc,
  input  logic                 stall_inc,
  output logic [CNT_WIDTH-1:0] perf_busy,
  output logic [CNT_WIDTH-1:0] perf_stall
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (busy_inc && (perf_busy != '1)) begin
        perf_busy <= perf_busy + CNT_WIDTH'(1);
      end
      if (stall_inc && (perf_stall != '1)) begin
        perf_stall <= perf_stall + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/kernel_bc_write_back_ctrl.sv
// rtl/kernel_bc_write_back_ctrl.sv - per start token, stream num_words data-FIFO words to a memory write port
// Optional build macro: KERNEL_BC_WB_PERF_CNT_EN (enables perf_busy / perf_stall counters)
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   start_empty_n/start_read/start_dout start-token FIFO (token value unused)
//   base_addr, num_words                job parameters, sampled on token pop
//   data_empty_n/data_read/data_dout    write-back data FIFO (FWFT)
//   wr_valid/wr_ready/wr_addr/wr_data   registered memory write request
//   ap_idle, ap_done                    idle level, one-cycle job-complete pulse
//   perf_busy, perf_stall               RUN cycles / RUN stall cycles (0 without the macro)
module kernel_bc_write_back_ctrl
  import kernel_bc_wb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic                  start_dout,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  data_empty_n,
  output logic                  data_read,
  input  logic [DATA_WIDTH-1:0] data_dout,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [CNT_WIDTH-1:0]  perf_busy,
  output logic [CNT_WIDTH-1:0]  perf_stall
);

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic                  rem_nz;
  logic                  wr_free;
  logic                  start_dout_unused;

  // The token carries no information; only its presence matters.
  assign start_dout_unused = start_dout;

  assign rem_nz  = (remaining != '0);
  // Output register can take a new word this cycle (empty or draining).
  assign wr_free = !wr_valid || wr_ready;

  assign ap_idle = (state == IDLE);
  assign ap_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO pops are suppressed while reset is asserted so a mid-job reset
  // leaves unconsumed data in the FIFO.
  always_comb begin
    state_nxt  = state;
    start_read = 1'b0;
    data_read  = 1'b0;
    case (state)
      IDLE: begin
        start_read = start_empty_n && !reset;
        if (start_empty_n) begin
          state_nxt = (num_words != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        data_read = data_empty_n && rem_nz && wr_free && !reset;
        if (!rem_nz && wr_free) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      remaining <= '0;
      addr_cnt  <= '0;
    end else begin
      if (start_read) begin
        addr_cnt  <= base_addr;
        remaining <= num_words;
      end
      if (data_read) begin
        wr_valid  <= 1'b1;
        wr_data   <= data_dout;
        wr_addr   <= addr_cnt;
        addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
        remaining <= remaining - CNT_WIDTH'(1);
      end else if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

`ifdef KERNEL_BC_WB_PERF_CNT_EN
  kernel_bc_wb_perf_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf_cnt (
    .clk        (clk),
    .reset      (reset),
    .busy_inc   (state == RUN),
    .stall_inc  ((state == RUN) && wr_valid && !wr_ready),
    .perf_busy  (perf_busy),
    .perf_stall (perf_stall)
  );
`else
  assign perf_busy  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_kernel_bc_write_back_ctrl.sv
// tb/tb_kernel_bc_write_back_ctrl.sv - scoreboard bench for kernel_bc_write_back_ctrl
module tb_kernel_bc_write_back_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_empty_n, start_read, start_dout;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_words;
  logic          data_empty_n, data_read;
  logic [DW-1:0] data_dout;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          ap_idle, ap_done;
  logic [CW-1:0] perf_busy, perf_stall;

  kernel_bc_write_back_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_empty_n (start_empty_n),
    .start_read    (start_read),
    .start_dout    (start_dout),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .data_empty_n  (data_empty_n),
    .data_read     (data_read),
    .data_dout     (data_dout),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .ap_idle       (ap_idle),
    .ap_done       (ap_done),
    .perf_busy     (perf_busy),
    .perf_stall    (perf_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [CW-1:0] n;
  } job_t;

  exp_t          exp_q[$];
  job_t          job_q[$];
  logic [DW-1:0] dat_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_evt = -100;
  int pop_cyc  = -100;
  int done_cyc = -100;
  bit first_pending = 0;
  bit tok_at_done   = 0;
  bit idle_next     = 0;
  int n_done = 0, n_dread = 0, n_hs = 0, n_wv = 0, n_b2b = 0;
  logic [AW-1:0] stall_addr = '0;
  int            stall_left = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic upd();
    start_empty_n = (job_q.size() != 0);
    base_addr     = start_empty_n ? job_q[0].base : '0;
    num_words     = start_empty_n ? job_q[0].n : '0;
    data_empty_n  = (dat_q.size() != 0);
    data_dout     = data_empty_n ? dat_q[0] : '0;
  endtask

  task automatic set_ready();
    wr_ready = 1'b1;
    if (wr_valid && (wr_addr == stall_addr) && (stall_left > 0)) begin
      wr_ready = 1'b0;
      stall_left--;
    end
  endtask

  task automatic push_job(input logic [AW-1:0] base, input logic [CW-1:0] n, input logic [DW-1:0] d0);
    job_t j;
    exp_t e;
    j.base = base;
    j.n    = n;
    job_q.push_back(j);
    for (int i = 0; i < int'(n); i++) begin
      dat_q.push_back(d0 + DW'(i));
      e.addr = base + AW'(i);
      e.data = d0 + DW'(i);
      e.last = (i == int'(n) - 1);
      exp_q.push_back(e);
    end
    upd();
  endtask

  // Observe one cycle at the falling edge, then apply FIFO pops after the rising edge.
  task automatic cycle();
    bit   do_s, do_d;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (idle_next) begin
      check("idle_after_done", ap_idle, 1);
      idle_next = 0;
    end
    if (prev_stall && wr_valid) begin
      check("hold_addr", wr_addr, prev_addr);
      check("hold_data", wr_data, prev_data);
    end
    if (wr_valid && !wr_ready) check("no_read_while_stalled", data_read, 0);
    if (wr_valid && first_pending) begin
      check("first_write_latency", cyc, pop_cyc + 2);
      first_pending = 0;
    end
    if (wr_valid) n_wv++;
    if (wr_valid && wr_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        if (e.last) last_evt = cyc;
      end
    end
    if (ap_done) begin
      n_done++;
      check("done_latency", cyc, last_evt + 1);
      done_cyc    = cyc;
      tok_at_done = start_empty_n;
      idle_next   = 1;
    end
    if (start_read) begin
      if (tok_at_done) begin
        check("b2b_pop", cyc, done_cyc + 1);
        n_b2b++;
        tok_at_done = 0;
      end
      if (num_words == '0) begin
        last_evt = cyc;
      end else begin
        pop_cyc       = cyc;
        first_pending = 1;
      end
    end
    if (data_read) n_dread++;
    prev_stall = wr_valid && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
    do_s = start_read;
    do_d = data_read;
    @(posedge clk);
    #1;
    if (do_s) void'(job_q.pop_front());
    if (do_d) void'(dat_q.pop_front());
    upd();
    set_ready();
  endtask

  task automatic run_until_done(input int target, input int limit);
    int k;
    k = 0;
    while ((n_done < target) && (k < limit)) begin
      cycle();
      k++;
    end
    check("done_seen", n_done, target);
    cycle();
  endtask

  initial begin
    int            hs0, dr0, wv0, k;
    logic [CW-1:0] pb0, ps0;

    reset      = 1'b1;
    start_dout = 1'b0;
    wr_ready   = 1'b1;
    upd();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ap_idle", ap_idle, 1);
    check("rst_ap_done", ap_done, 0);
    check("rst_start_read", start_read, 0);
    check("rst_perf_busy", perf_busy, 0);
    check("rst_perf_stall", perf_stall, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    upd();
    set_ready();

    // Basic 4-word job at full throughput.
    hs0 = n_hs;
    push_job(32'h100, 4, 32'hA);
    run_until_done(1, 40);
    check("basic_writes", n_hs - hs0, 4);
    check("basic_span", done_cyc, pop_cyc + 6);

    // Backpressure: word at 0x202 held for 3 cycles.
    hs0        = n_hs;
    pb0        = perf_busy;
    ps0        = perf_stall;
    stall_addr = 32'h202;
    stall_left = 3;
    push_job(32'h200, 4, 32'h50);
    run_until_done(2, 60);
    check("bp_writes", n_hs - hs0, 4);
    check("bp_span", done_cyc, pop_cyc + 9);
    check("bp_data_fifo_empty", dat_q.size(), 0);
`ifdef KERNEL_BC_WB_PERF_CNT_EN
    check("perf_busy_delta", perf_busy - pb0, 8);
    check("perf_stall_delta", perf_stall - ps0, 3);
`else
    check("perf_busy_off", perf_busy, 0);
    check("perf_stall_off", perf_stall, 0);
`endif

    // Zero-length job.
    hs0 = n_hs;
    dr0 = n_dread;
    wv0 = n_wv;
    push_job(32'h400, 0, 32'h0);
    run_until_done(3, 20);
    check("zero_no_reads", n_dread - dr0, 0);
    check("zero_no_valid", n_wv - wv0, 0);
    check("zero_no_writes", n_hs - hs0, 0);

    // Address wrap with a second token already queued.
    hs0 = n_hs;
    push_job(32'hFFFF_FFFE, 3, 32'h70);
    push_job(32'h300, 2, 32'h80);
    run_until_done(5, 80);
    check("wrap_b2b_writes", n_hs - hs0, 5);
    check("b2b_seen", n_b2b, 1);
    check("wrap_exp_empty", exp_q.size(), 0);

    // Reset after the second of five writes.
    push_job(32'h500, 5, 32'h90);
    k = 0;
    while (!(wr_valid && (wr_addr == 32'h501)) && (k < 40)) begin
      cycle();
      k++;
    end
    check("rst_mid_reach", wr_addr, 32'h501);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_wr_valid", wr_valid, 0);
    check("rst_mid_ap_idle", ap_idle, 1);
    check("rst_mid_ap_done", ap_done, 0);
    check("rst_mid_data_left", dat_q.size(), 3);
    check("rst_mid_no_read", data_read, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
